serial_digit_adder: RTL

//  Multi-cycle add/subtract unit processing a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first.

---
 rtl/serial_digit_adder_pkg.sv | 16 +
 rtl/serial_digit_adder_slice.sv | 27 ++
 rtl/serial_digit_adder.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
package serial_digit_adder_pkg;

  // Operation sequencing: accept operands, step through digits, hold result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter width for a digit count, never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder_slice.sv
// One digit of the serial adder: a ripple of 1-bit full adders.
// Also exposes the carry into the top bit so the top can form overflow.
module digit_adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the digit.
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/subtract of WIDTH-bit operands, DIGIT bits per clock,
// least-significant digit first, with valid/ready on both sides.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_c_msb;
  logic             accept, last_dig;

  // Sum digits enter from the top; after NDIG shifts digit 0 sits at the LSB.
  logic [WIDTH+DIGIT-1:0] sum_cat;
  assign sum_cat = {dig_s, sum_q};

  assign accept   = (state == S_IDLE) && in_valid;
  assign last_dig = (cnt == LAST_DIG);

  digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_c_msb)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: the default is assigned before the case so no path leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last_dig)  state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then process one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1; cin has no say in that case.
      cnt     <= '0;
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
    end else if (state == S_RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
      carry_q <= dig_cout;
      cnt     <= cnt + 1'b1;
      if (last_dig) begin
        cout_q <= dig_cout;
        ovf_q  <= dig_c_msb ^ dig_cout;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
